audio_sd_mixer: RTL

//  Output stage downstream of the chipset sound sources. Sample-and-holds the OPL2, Tandy and PC-speaker

---
 rtl/audio_sd_mixer.sv | 115 +++++++++++
 1 files changed

// File: rtl/audio_sd_mixer.sv
// audio_sd_mixer: sample-hold source mixer with saturation, pop-free mute ramp and 1-bit sigma-delta DAC
module audio_sd_mixer #(
  parameter int OPL_SHIFT   = 1,
  parameter int TANDY_SHIFT = 6,
  parameter int SPK_LEVEL   = 8192,
  parameter int FILT_SHIFT  = 7,
  parameter int RAMP_DIV    = 256,
  parameter int RAMP_STEP   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [15:0] opl_in,
  input  logic [9:0]  tandy_in,
  input  logic        speaker_in,
  input  logic        mute,
  input  logic        clip_clr,
  output logic        aud_l,
  output logic        aud_r,
  output logic        clip,
  output logic [15:0] level
);
  typedef enum logic [1:0] {RAMP_UP, RUN, RAMP_DOWN, MUTED} state_t;
  localparam logic [15:0] MID = 16'h8000;
  localparam logic signed [19:0] SPK = 20'(SPK_LEVEL);
  logic [15:0] opl_q;
  logic [9:0]  tan_q;
  logic        spk_q, mix_q;
  logic [15:0] amp_q, amp_d, lvl_q, lvl_d;
  logic [31:0] acc_q, acc_d, cnt_q, cnt_d;
  logic        clip_q, clip_d, aud_q, sign;
  state_t      st_q, st_d;
  logic signed [19:0] opl_x, tan_x, sum;
  logic        sat_hi, sat_lo, ramp, tick;
  logic [16:0] up, dn;
  logic [15:0] up_c, dn_c, toward;
  // Mixer is wider than the 16-bit output so every source combination saturates instead of wrapping
  assign opl_x  = {{4{opl_q[15]}}, opl_q};
  assign tan_x  = {10'b0, tan_q};
  assign sum    = (opl_x <<< OPL_SHIFT) + (tan_x <<< TANDY_SHIFT) + (spk_q ? SPK : 20'sd0);
  assign sat_hi = sum > 20'sd32767;
  assign sat_lo = sum < -20'sd32768;
  assign amp_d  = !mix_q ? amp_q : sat_hi ? 16'hFFFF : sat_lo ? 16'h0000 : {~sum[15], sum[14:0]};
  assign clip_d = clip_clr ? 1'b0 : clip_q | (mix_q & (sat_hi | sat_lo));
  // Ramp divider runs only in ramp states and idles at 0 elsewhere, so each ramp entry starts fresh
  assign ramp   = (st_q == RAMP_UP) || (st_q == RAMP_DOWN);
  assign tick   = ramp && (cnt_q == RAMP_DIV - 1);
  assign cnt_d  = (ramp && !tick) ? cnt_q + 32'd1 : 32'd0;
  assign up     = {1'b0, lvl_q} + 17'(RAMP_STEP);
  assign dn     = {1'b0, lvl_q} - 17'(RAMP_STEP);
  assign up_c   = (up > 17'h08000) ? MID : up[15:0];
  assign dn_c   = (dn[16] || dn[15:0] < MID) ? MID : dn[15:0];
  assign toward = (lvl_q > MID) ? dn_c : up_c;
  // Level FSM: soft-start from zero, track the mix in RUN, glide to midscale when muted
  always_comb begin
    st_d  = st_q;
    lvl_d = lvl_q;
    case (st_q)
      RAMP_UP: begin
        if (lvl_q == MID) st_d = mute ? MUTED : RUN;
        else if (tick) lvl_d = up_c;
      end
      RUN: begin
        lvl_d = amp_q;
        if (mute) st_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (!mute) st_d = RUN;
        else if (lvl_q == MID) st_d = MUTED;
        else if (tick) lvl_d = toward;
      end
      default: begin
        lvl_d = MID;
        if (!mute) st_d = RUN;
      end
    endcase
  end
  // First-order leaky sigma-delta: duty of the output bit settles near lvl/65536
  assign sign  = acc_q[31:16] < lvl_q;
  assign acc_d = acc_q - (acc_q >> FILT_SHIFT) + (sign ? 32'h0200_0000 : 32'h0);
  // All state registers with asynchronous reset to a silent, ramp-from-zero start
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opl_q  <= '0;
      tan_q  <= '0;
      spk_q  <= 1'b0;
      mix_q  <= 1'b0;
      amp_q  <= MID;
      lvl_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      clip_q <= 1'b0;
      aud_q  <= 1'b0;
      st_q   <= RAMP_UP;
    end else begin
      if (sample_en) begin
        opl_q <= opl_in;
        tan_q <= tandy_in;
        spk_q <= speaker_in;
      end
      mix_q  <= sample_en;
      amp_q  <= amp_d;
      lvl_q  <= lvl_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      clip_q <= clip_d;
      aud_q  <= sign;
      st_q   <= st_d;
    end
  end
  assign aud_l = aud_q;
  assign aud_r = aud_q;
  assign clip  = clip_q;
  assign level = lvl_q;
endmodule
